instr_dispatch_unit: RTL and testbench
======================================

INSTR_DISPATCH_UNIT -- requirements
Module: instr_dispatch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand/result width.
REQ-002 The block SHALL have parameter TIMEOUT, default 64: maximum number of WAIT cycles before abort.
REQ-003 The block SHALL have a fixed class order: 0=R 1=I 2=S 3=B 4=U 5=J 6=M 7=A 8=F. NCLS=9.
REQ-004 The block SHALL have the following ports:
- iCLK, in, 1: clock. All logic is on the rising edge.
- iRSTN, in, 1: reset. Synchronous, active-low.
- iIR, in, 32: instruction.
- iIR_VALID, in, 1: instruction offered.
- oIR_READY, out, 1: block can accept an instruction.
- iALU_IN1 / iALU_IN2, in, XLEN: operands, sampled together with iIR.
- oUNIT_VALID, out, NCLS: one-hot issue request.
- iUNIT_READY, in, NCLS: unit accepts the issue.
- oALU_IN1 / oALU_IN2, out, XLEN: latched operands, shared bus.
- oRD / oRS1 / oRS2, out, 5: decoded register fields.
- iUNIT_DONE, in, NCLS: unit result valid.
- iUNIT_RESULT, in, NCLS*XLEN: result slices; slice k is [k*XLEN +: XLEN].
- oRESULT, out, XLEN: captured result.
- oRESULT_RD, out, 5: destination register.
- oRESULT_WE, out, 1: register write enable.
- oRESULT_VALID, out, 1: result offered.
- iRESULT_READY, in, 1: consumer accepts the result.
- oILLEGAL, out, 1: one-cycle pulse for an undecodable instruction.
- oTIMEOUT, out, 1: one-cycle pulse for an aborted instruction.

Function
REQ-005 Decode SHALL map opcodes to classes as follows:
- 0110011 with funct7=0000001 -> M; 0110011 otherwise -> R.
- 0010011, 0000011, 1100111 -> I.
- 0100011 -> S.
- 1100011 -> B.
- 0110111, 0010111 -> U.
- 1101111 -> J.
- 0101111 -> A.
- 0000111, 0100111, 1010011 -> F.
- Any other opcode -> illegal.
REQ-006 Register fields SHALL be zeroed where a class has no such field:
- rd is zero for S and B.
- rs1 and rs2 are zero for U and J.
- rs2 is zero for I and F.
- For F, rd is nonzero only when funct7 is 1100000, 1110000 or 1010000.
REQ-007 The FSM SHALL have four states: IDLE, ISSUE, WAIT, WB.
REQ-008 In IDLE, oIR_READY=1. On iIR_VALID&&oIR_READY the block SHALL latch iIR, iALU_IN1, iALU_IN2 and the decoded class, then:
- legal: go to ISSUE;
- illegal: stay in IDLE and pulse oILLEGAL the next cycle.
REQ-009 oIR_READY SHALL be 0 in every state except IDLE, so at most one instruction is outstanding.
REQ-010 In ISSUE, oUNIT_VALID[class]=1 SHALL be held until iUNIT_READY[class]=1, then the FSM goes to WAIT with the timeout counter cleared.
REQ-011 If iUNIT_DONE[class] is 1 in the same cycle as the ISSUE handshake, the result SHALL be captured and the FSM SHALL go directly to WB.
REQ-012 In WAIT, the counter SHALL increment each cycle. On iUNIT_DONE[class], the block SHALL capture slice[class] into oRESULT and go to WB.
REQ-013 In WAIT, if the counter reaches TIMEOUT-1 with no done, the block SHALL pulse oTIMEOUT for one cycle, go to IDLE and produce no WB. If done arrives in that same cycle, done SHALL win.
REQ-014 iUNIT_DONE and iUNIT_READY bits of non-selected classes SHALL be ignored in every state.
REQ-015 In WB, oRESULT_VALID=1 SHALL be held with oRESULT, oRESULT_RD and oRESULT_WE stable until iRESULT_READY=1, then the FSM goes to IDLE.
REQ-016 oRESULT_WE SHALL be 1 only when the class is R, I, U, J, M, A or F and oRESULT_RD!=0.
REQ-017 oALU_IN1, oALU_IN2, oRD, oRS1 and oRS2 SHALL hold their latched values from acceptance until the next acceptance.
REQ-018 Best-case latency SHALL be: acceptance at T0, ISSUE with handshake and done at T1, oRESULT_VALID at T2, IDLE at T3, for a throughput of one instruction per 3 cycles.

Reset
REQ-019 While iRSTN=0 at a clock edge, the block SHALL go to IDLE, clear the counter, and zero oRESULT, oRESULT_RD, oRESULT_WE, oRESULT_VALID, oUNIT_VALID, oALU_IN1/2, oRD, oRS1, oRS2, oILLEGAL and oTIMEOUT. oIR_READY SHALL be 1 from the first cycle after reset is released.
REQ-020 Reset asserted in any state SHALL abandon the in-flight instruction with no pulse on oILLEGAL or oTIMEOUT.

Configuration
REQ-021 When DISPATCH_FP_EN is defined, class F SHALL be decoded per REQ-005 and REQ-006.
REQ-022 When DISPATCH_FP_EN is undefined, opcodes 0000111, 0100111 and 1010011 SHALL be illegal, oUNIT_VALID[8] and oRESULT_WE for class F SHALL be tied to 0, and the port widths SHALL be unchanged.

Verification
REQ-023 add x3,x1,x2 (0x002081B3), IN1=5, IN2=7, unit R ready and done at T1 with result 12 -> oRESULT_VALID at T2 with oRESULT=12, RD=3, WE=1.
REQ-024 mul (funct7=0000001), unit M ready at once, done 4 cycles later -> oUNIT_VALID=0x040, no other bit set, oRESULT_VALID 1 cycle after done.
REQ-025 sw (0x0020A023) -> class S, oRESULT_WE=0, oRESULT_RD=0.
REQ-026 Opcode 1111111 -> oILLEGAL pulse of exactly 1 cycle, and oIR_READY stays 1.
REQ-027 TIMEOUT=8, unit never done -> oTIMEOUT pulses 8 cycles after the ISSUE handshake, and the next instruction is accepted.
REQ-028 iRSTN=0 in WB with iRESULT_READY=0 -> all outputs zero the next cycle; build without DISPATCH_FP_EN, issue 0x00000053 -> oILLEGAL.

Source files
------------

// File: rtl/instr_dispatch_if.sv
// Bus bundle between instr_dispatch_unit and its instruction source, execution units
// and result consumer; master is the dispatch side, slave is the environment side.
interface instr_dispatch_if #(
  parameter int XLEN = 32,
  parameter int NCLS = 9
);
  logic [31:0]          iIR;
  logic                 iIR_VALID;
  logic                 oIR_READY;
  logic [XLEN-1:0]      iALU_IN1;
  logic [XLEN-1:0]      iALU_IN2;
  logic [NCLS-1:0]      oUNIT_VALID;
  logic [NCLS-1:0]      iUNIT_READY;
  logic [XLEN-1:0]      oALU_IN1;
  logic [XLEN-1:0]      oALU_IN2;
  logic [4:0]           oRD;
  logic [4:0]           oRS1;
  logic [4:0]           oRS2;
  logic [NCLS-1:0]      iUNIT_DONE;
  logic [NCLS*XLEN-1:0] iUNIT_RESULT;
  logic [XLEN-1:0]      oRESULT;
  logic [4:0]           oRESULT_RD;
  logic                 oRESULT_WE;
  logic                 oRESULT_VALID;
  logic                 iRESULT_READY;
  logic                 oILLEGAL;
  logic                 oTIMEOUT;

  modport master (
    input  iIR, iIR_VALID, iALU_IN1, iALU_IN2, iUNIT_READY, iUNIT_DONE,
           iUNIT_RESULT, iRESULT_READY,
    output oIR_READY, oUNIT_VALID, oALU_IN1, oALU_IN2, oRD, oRS1, oRS2,
           oRESULT, oRESULT_RD, oRESULT_WE, oRESULT_VALID, oILLEGAL, oTIMEOUT
  );

  modport slave (
    output iIR, iIR_VALID, iALU_IN1, iALU_IN2, iUNIT_READY, iUNIT_DONE,
           iUNIT_RESULT, iRESULT_READY,
    input  oIR_READY, oUNIT_VALID, oALU_IN1, oALU_IN2, oRD, oRS1, oRS2,
           oRESULT, oRESULT_RD, oRESULT_WE, oRESULT_VALID, oILLEGAL, oTIMEOUT
  );
endinterface

// File: rtl/instr_dispatch_unit.sv
// Single-outstanding instruction dispatcher: decode, issue to one of 9 unit classes, wait, write back.
// Define DISPATCH_FP_EN to decode the floating-point class F; otherwise F opcodes are illegal.
module instr_dispatch_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             iCLK,
  input  logic             iRSTN,
  instr_dispatch_if.master bus
);
  localparam int NCLS = 9;
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [3:0] C_R = 4'd0;
  localparam logic [3:0] C_I = 4'd1;
  localparam logic [3:0] C_S = 4'd2;
  localparam logic [3:0] C_B = 4'd3;
  localparam logic [3:0] C_U = 4'd4;
  localparam logic [3:0] C_J = 4'd5;
  localparam logic [3:0] C_M = 4'd6;
  localparam logic [3:0] C_A = 4'd7;
  localparam logic [3:0] C_F = 4'd8;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [NCLS-1:0] r_cls_oh;
  logic [NCLS-1:0] r_unit_valid;
  logic [XLEN-1:0] r_alu1;
  logic [XLEN-1:0] r_alu2;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic            r_wr;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_result_rd;
  logic            r_result_we;
  logic            r_result_valid;
  logic            r_illegal;
  logic            r_timeout;

  logic [6:0]      w_opc;
  logic [6:0]      w_f7;
  logic [3:0]      w_cls;
  logic            w_legal;
  logic [NCLS-1:0] w_cls_oh;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_wr;
  logic            w_sel_ready;
  logic            w_sel_done;
  logic [XLEN-1:0] w_sel_result;

  assign w_opc    = bus.iIR[6:0];
  assign w_f7     = bus.iIR[31:25];
  assign w_cls_oh = NCLS'(1) << w_cls;

  // Opcode to class decode.
  always_comb begin
    w_legal = 1'b1;
    w_cls   = C_R;
    case (w_opc)
      7'b0110011:                         w_cls = (w_f7 == 7'b0000001) ? C_M : C_R;
      7'b0010011, 7'b0000011, 7'b1100111: w_cls = C_I;
      7'b0100011:                         w_cls = C_S;
      7'b1100011:                         w_cls = C_B;
      7'b0110111, 7'b0010111:             w_cls = C_U;
      7'b1101111:                         w_cls = C_J;
      7'b0101111:                         w_cls = C_A;
`ifdef DISPATCH_FP_EN
      7'b0000111, 7'b0100111, 7'b1010011: w_cls = C_F;
`endif
      default:                            w_legal = 1'b0;
    endcase
  end

  // Register fields, zeroed where the class has no such field; illegal words keep raw fields.
  always_comb begin
    w_rd  = bus.iIR[11:7];
    w_rs1 = bus.iIR[19:15];
    w_rs2 = bus.iIR[24:20];
    case (w_cls)
      C_S, C_B: w_rd = 5'd0;
      C_U, C_J: begin
        w_rs1 = 5'd0;
        w_rs2 = 5'd0;
      end
      C_I:      w_rs2 = 5'd0;
      C_F: begin
        w_rs2 = 5'd0;
        w_rd  = (w_f7 == 7'b1100000 || w_f7 == 7'b1110000 || w_f7 == 7'b1010000) ?
                bus.iIR[11:7] : 5'd0;
      end
      default:  w_rd = bus.iIR[11:7];
    endcase
    w_wr = (w_cls != C_S) && (w_cls != C_B) && (w_rd != 5'd0);
  end

  // Only the latched class's ready/done/result lanes are observed.
  always_comb begin
    w_sel_ready  = |(bus.iUNIT_READY & r_cls_oh);
    w_sel_done   = |(bus.iUNIT_DONE & r_cls_oh);
    w_sel_result = '0;
    for (int k = 0; k < NCLS; k++) begin
      w_sel_result = w_sel_result | (bus.iUNIT_RESULT[k*XLEN +: XLEN] & {XLEN{r_cls_oh[k]}});
    end
  end

  // Dispatch state machine with operand/result latches.
  always_ff @(posedge iCLK) begin
    if (!iRSTN) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_cls_oh       <= '0;
      r_unit_valid   <= '0;
      r_alu1         <= '0;
      r_alu2         <= '0;
      r_rd           <= 5'd0;
      r_rs1          <= 5'd0;
      r_rs2          <= 5'd0;
      r_wr           <= 1'b0;
      r_result       <= '0;
      r_result_rd    <= 5'd0;
      r_result_we    <= 1'b0;
      r_result_valid <= 1'b0;
      r_illegal      <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.iIR_VALID) begin
            r_alu1   <= bus.iALU_IN1;
            r_alu2   <= bus.iALU_IN2;
            r_rd     <= w_rd;
            r_rs1    <= w_rs1;
            r_rs2    <= w_rs2;
            r_wr     <= w_wr;
            r_cls_oh <= w_legal ? w_cls_oh : '0;
            if (w_legal) begin
              r_unit_valid <= w_cls_oh;
              r_state      <= S_ISSUE;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_sel_ready) begin
            r_unit_valid <= '0;
            r_cnt        <= '0;
            if (w_sel_done) begin
              r_result       <= w_sel_result;
              r_result_rd    <= r_rd;
              r_result_we    <= r_wr;
              r_result_valid <= 1'b1;
              r_state        <= S_WB;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A done arriving on the last counted cycle still wins over the abort.
          if (w_sel_done) begin
            r_result       <= w_sel_result;
            r_result_rd    <= r_rd;
            r_result_we    <= r_wr;
            r_result_valid <= 1'b1;
            r_state        <= S_WB;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WB: begin
          if (bus.iRESULT_READY) begin
            r_result_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oIR_READY     = (r_state == S_IDLE);
  assign bus.oALU_IN1      = r_alu1;
  assign bus.oALU_IN2      = r_alu2;
  assign bus.oRD           = r_rd;
  assign bus.oRS1          = r_rs1;
  assign bus.oRS2          = r_rs2;
  assign bus.oRESULT       = r_result;
  assign bus.oRESULT_RD    = r_result_rd;
  assign bus.oRESULT_VALID = r_result_valid;
  assign bus.oILLEGAL      = r_illegal;
  assign bus.oTIMEOUT      = r_timeout;
`ifdef DISPATCH_FP_EN
  assign bus.oUNIT_VALID   = r_unit_valid;
  assign bus.oRESULT_WE    = r_result_we;
`else
  assign bus.oUNIT_VALID   = {1'b0, r_unit_valid[NCLS-2:0]};
  assign bus.oRESULT_WE    = r_result_we & ~r_cls_oh[C_F];
`endif
endmodule

// File: tb/tb_instr_dispatch_unit.sv
// Self-checking bench for instr_dispatch_unit: directed scenarios, then randomized traffic
// compared every cycle against a transaction-level model of the dispatcher.
module tb_instr_dispatch_unit;
  localparam int XLEN = 32;
  localparam int NCLS = 9;
  localparam int TMO  = 8;
`ifdef DISPATCH_FP_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  instr_dispatch_if #(.XLEN(XLEN), .NCLS(NCLS)) bus ();

  instr_dispatch_unit #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .iCLK  (clk),
    .iRSTN (rstn),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Model: one pending instruction, described by flags rather than FSM states.
  bit          m_busy, m_issued, m_res_pend, m_ill, m_to, m_we, m_res_we;
  int          m_waited, m_cls;
  logic [31:0] m_in1, m_in2, m_res;
  logic [4:0]  m_rd, m_rs1, m_rs2, m_res_rd;

  function automatic int cls_of(input logic [31:0] ir);
    case (ir[6:0])
      7'h33:               return (ir[31:25] == 7'h01) ? 6 : 0;
      7'h13, 7'h03, 7'h67: return 1;
      7'h23:               return 2;
      7'h63:               return 3;
      7'h37, 7'h17:        return 4;
      7'h6F:               return 5;
      7'h2F:               return 7;
      7'h07, 7'h27, 7'h53: return FP_EN ? 8 : -1;
      default:             return -1;
    endcase
  endfunction

  task automatic capture();
    m_res      = bus.iUNIT_RESULT[m_cls*XLEN +: XLEN];
    m_res_rd   = m_rd;
    m_res_we   = m_we;
    m_res_pend = 1'b1;
  endtask

  task automatic model_step();
    logic [31:0] ir;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    int          c;
    m_ill = 1'b0;
    m_to  = 1'b0;
    if (!rstn) begin
      m_busy = 1'b0; m_issued = 1'b0; m_res_pend = 1'b0; m_we = 1'b0; m_res_we = 1'b0;
      m_waited = 0; m_cls = 0;
      m_in1 = '0; m_in2 = '0; m_res = '0;
      m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_res_rd = '0;
    end else if (!m_busy) begin
      if (bus.iIR_VALID) begin
        ir = bus.iIR; f7 = ir[31:25]; c = cls_of(ir);
        rd = ir[11:7]; rs1 = ir[19:15]; rs2 = ir[24:20];
        if (c == 2 || c == 3) rd = 5'd0;
        if (c == 4 || c == 5) begin rs1 = 5'd0; rs2 = 5'd0; end
        if (c == 1 || c == 8) rs2 = 5'd0;
        if (c == 8 && !(f7 == 7'h60 || f7 == 7'h70 || f7 == 7'h50)) rd = 5'd0;
        m_in1 = bus.iALU_IN1; m_in2 = bus.iALU_IN2;
        m_rd = rd; m_rs1 = rs1; m_rs2 = rs2;
        m_we = (c >= 0) && (c != 2) && (c != 3) && (rd != 5'd0);
        if (c < 0) m_ill = 1'b1;
        else begin m_busy = 1'b1; m_issued = 1'b0; m_cls = c; end
      end
    end else if (m_res_pend) begin
      if (bus.iRESULT_READY) begin m_res_pend = 1'b0; m_busy = 1'b0; end
    end else if (!m_issued) begin
      if (bus.iUNIT_READY[m_cls]) begin
        if (bus.iUNIT_DONE[m_cls]) capture();
        else begin m_issued = 1'b1; m_waited = 0; end
      end
    end else begin
      if (bus.iUNIT_DONE[m_cls]) capture();
      else if (m_waited == TMO - 1) begin m_to = 1'b1; m_busy = 1'b0; end
      else m_waited++;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare();
    logic [8:0] uv;
    uv = (m_busy && !m_issued && !m_res_pend) ? (9'd1 << m_cls) : 9'd0;
    chk("ir_ready",     bus.oIR_READY, !m_busy);
    chk("unit_valid",   bus.oUNIT_VALID, uv);
    chk("alu_in1",      bus.oALU_IN1, m_in1);
    chk("alu_in2",      bus.oALU_IN2, m_in2);
    chk("rd",           bus.oRD, m_rd);
    chk("rs1",          bus.oRS1, m_rs1);
    chk("rs2",          bus.oRS2, m_rs2);
    chk("result",       bus.oRESULT, m_res);
    chk("result_rd",    bus.oRESULT_RD, m_res_rd);
    chk("result_we",    bus.oRESULT_WE, m_res_we);
    chk("result_valid", bus.oRESULT_VALID, m_res_pend);
    chk("illegal",      bus.oILLEGAL, m_ill);
    chk("timeout",      bus.oTIMEOUT, m_to);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_inputs();
    bus.iIR = '0; bus.iIR_VALID = 1'b0; bus.iALU_IN1 = '0; bus.iALU_IN2 = '0;
    bus.iUNIT_READY = '0; bus.iUNIT_DONE = '0; bus.iUNIT_RESULT = '0; bus.iRESULT_READY = 1'b0;
  endtask

  function automatic logic [31:0] gen_ir();
    logic [31:0] ir;
    ir = $urandom();
    case ($urandom_range(0, 15))
      0:  ir[6:0] = 7'h33;
      1:  begin ir[6:0] = 7'h33; ir[31:25] = 7'h01; end
      2:  ir[6:0] = 7'h13;
      3:  ir[6:0] = 7'h03;
      4:  ir[6:0] = 7'h67;
      5:  ir[6:0] = 7'h23;
      6:  ir[6:0] = 7'h63;
      7:  ir[6:0] = 7'h37;
      8:  ir[6:0] = 7'h17;
      9:  ir[6:0] = 7'h6F;
      10: ir[6:0] = 7'h2F;
      11: ir[6:0] = 7'h07;
      12: begin ir[6:0] = 7'h53; ir[31:25] = 7'h60; end
      13: ir[6:0] = 7'h27;
      default: ir[6:0] = ir[6:0];
    endcase
    return ir;
  endfunction

  task automatic rand_inputs(input int cyc);
    bus.iIR_VALID   = ($urandom_range(0, 1) == 1);
    bus.iIR         = gen_ir();
    bus.iALU_IN1    = $urandom();
    bus.iALU_IN2    = $urandom();
    bus.iUNIT_READY = 9'($urandom_range(0, 511));
    if ((cyc / 100) % 2 == 0) bus.iUNIT_DONE = 9'($urandom());
    else bus.iUNIT_DONE = 9'($urandom() & $urandom() & $urandom());
    for (int k = 0; k < NCLS; k++) bus.iUNIT_RESULT[k*XLEN +: XLEN] = $urandom();
    bus.iRESULT_READY = ($urandom_range(0, 1) == 1);
    rstn = ($urandom_range(0, 63) != 0);
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    clear_inputs();
    repeat (3) cycle();
    chk("rst_ir_ready", bus.oIR_READY, 64'd1);
    chk("rst_unit_valid", bus.oUNIT_VALID, 64'd0);
    chk("rst_result_valid", bus.oRESULT_VALID, 64'd0);
    rstn = 1'b1;

    // add x3,x1,x2: best-case latency path
    bus.iIR = 32'h002081B3; bus.iIR_VALID = 1'b1; bus.iALU_IN1 = 32'd5; bus.iALU_IN2 = 32'd7;
    cycle();
    chk("add_uv", bus.oUNIT_VALID, 64'h001);
    chk("add_in1", bus.oALU_IN1, 64'd5);
    chk("add_ready_low", bus.oIR_READY, 64'd0);
    bus.iIR_VALID = 1'b0; bus.iUNIT_READY = 9'h001; bus.iUNIT_DONE = 9'h001;
    bus.iUNIT_RESULT[0 +: 32] = 32'd12;
    cycle();
    chk("add_rv", bus.oRESULT_VALID, 64'd1);
    chk("add_res", bus.oRESULT, 64'd12);
    chk("add_res_rd", bus.oRESULT_RD, 64'd3);
    chk("add_we", bus.oRESULT_WE, 64'd1);
    bus.iUNIT_READY = '0; bus.iUNIT_DONE = '0; bus.iRESULT_READY = 1'b1;
    cycle();
    chk("add_idle", bus.oIR_READY, 64'd1);

    // mul x5,x1,x2: unit M, done after waiting; other lanes toggling must be ignored
    clear_inputs();
    bus.iIR = 32'h022082B3; bus.iIR_VALID = 1'b1; bus.iUNIT_READY = 9'h040;
    cycle();
    chk("mul_uv", bus.oUNIT_VALID, 64'h040);
    bus.iIR_VALID = 1'b0;
    cycle();
    bus.iUNIT_READY = 9'h1BF; bus.iUNIT_DONE = 9'h1BF;
    repeat (3) cycle();
    chk("mul_not_yet", bus.oRESULT_VALID, 64'd0);
    bus.iUNIT_DONE = 9'h040; bus.iUNIT_RESULT[6*32 +: 32] = 32'h0000_1234;
    cycle();
    chk("mul_rv", bus.oRESULT_VALID, 64'd1);
    chk("mul_res", bus.oRESULT, 64'h1234);
    chk("mul_res_rd", bus.oRESULT_RD, 64'd5);
    bus.iUNIT_DONE = '0; bus.iRESULT_READY = 1'b1;
    cycle();

    // sw: class S, no writeback
    clear_inputs();
    bus.iIR = 32'h0020A023; bus.iIR_VALID = 1'b1;
    cycle();
    chk("sw_uv", bus.oUNIT_VALID, 64'h004);
    chk("sw_rs1", bus.oRS1, 64'd1);
    chk("sw_rs2", bus.oRS2, 64'd2);
    bus.iIR_VALID = 1'b0; bus.iUNIT_READY = 9'h004; bus.iUNIT_DONE = 9'h004;
    cycle();
    chk("sw_rv", bus.oRESULT_VALID, 64'd1);
    chk("sw_we", bus.oRESULT_WE, 64'd0);
    chk("sw_res_rd", bus.oRESULT_RD, 64'd0);
    bus.iUNIT_READY = '0; bus.iUNIT_DONE = '0; bus.iRESULT_READY = 1'b1;
    cycle();

    // illegal opcode 1111111
    clear_inputs();
    bus.iIR = 32'h0000007F; bus.iIR_VALID = 1'b1;
    cycle();
    chk("ill_pulse", bus.oILLEGAL, 64'd1);
    chk("ill_ready", bus.oIR_READY, 64'd1);
    bus.iIR_VALID = 1'b0;
    cycle();
    chk("ill_pulse_end", bus.oILLEGAL, 64'd0);

    // timeout: unit accepts, never completes
    bus.iIR = 32'h00100093; bus.iIR_VALID = 1'b1; bus.iUNIT_READY = 9'h002;
    cycle();
    bus.iIR_VALID = 1'b0;
    cycle();
    bus.iUNIT_READY = '0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (bus.oTIMEOUT === 1'b1) begin n = i; break; end
    end
    chk("tmo_delay", 64'(n), 64'd8);
    chk("tmo_ready", bus.oIR_READY, 64'd1);
    bus.iIR = 32'h002081B3; bus.iIR_VALID = 1'b1;
    cycle();
    chk("tmo_next_uv", bus.oUNIT_VALID, 64'h001);
    chk("tmo_pulse_end", bus.oTIMEOUT, 64'd0);
    bus.iIR_VALID = 1'b0; bus.iUNIT_READY = 9'h001; bus.iUNIT_DONE = 9'h001;
    bus.iUNIT_RESULT[0 +: 32] = 32'hDEAD_BEEF;
    cycle();
    chk("wb_rv", bus.oRESULT_VALID, 64'd1);

    // reset while holding a result in writeback
    rstn = 1'b0; bus.iRESULT_READY = 1'b0;
    cycle();
    chk("rst_wb_rv", bus.oRESULT_VALID, 64'd0);
    chk("rst_wb_res", bus.oRESULT, 64'd0);
    chk("rst_wb_rd", bus.oRESULT_RD, 64'd0);
    chk("rst_wb_we", bus.oRESULT_WE, 64'd0);
    chk("rst_wb_in1", bus.oALU_IN1, 64'd0);
    chk("rst_wb_ill", bus.oILLEGAL, 64'd0);
    chk("rst_wb_to", bus.oTIMEOUT, 64'd0);
    rstn = 1'b1;
    clear_inputs();
    cycle();

    // FP opcode 1010011
    bus.iIR = 32'h00000053; bus.iIR_VALID = 1'b1;
    cycle();
`ifdef DISPATCH_FP_EN
    chk("fp_uv", bus.oUNIT_VALID, 64'h100);
`else
    chk("fp_illegal", bus.oILLEGAL, 64'd1);
`endif
    bus.iIR_VALID = 1'b0; bus.iUNIT_READY = 9'h1FF; bus.iUNIT_DONE = 9'h1FF;
    bus.iRESULT_READY = 1'b1;
    repeat (3) cycle();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_inputs(cyc);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
